// File: rtl/ps2_kbd_tx_pkg.sv
// Shared definitions for the PS/2 keyboard transmitter: FSM encoding, frame
// length, scan-code prefixes and the frame builder.
package ps2_kbd_tx_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, LOW, GAP} state_e;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Bit 0 goes on the wire first: start, data LSB first, odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous 8-bit scan-code FIFO with occupancy output; head is visible
// without popping so an aborted frame can be resent.
module ps2_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [7:0]             push_dat_i,
  output logic                   push_rdy_o,
  input  logic                   pop_i,
  output logic [7:0]             head_dat_o,
  output logic                   head_vld_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign push_rdy_o = (count_q != FULL_CNT);
  assign head_vld_o = (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    do_push  = push_i && push_rdy_o;
    do_pop   = pop_i && head_vld_o;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-to-host transmitter: buffers scan codes and clocks each out as an
// 11-bit frame; host inhibit aborts the frame and the byte is resent later.
module ps2_kbd_tx
  import ps2_kbd_tx_pkg::*;
#(
  parameter int HALF_PERIOD = 50,
  parameter int GAP_CYCLES  = 200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        host_inhibit,
  output logic                        ps2_clk,
  output logic                        ps2_data,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            bit_q;
  logic [FRAME_BITS-2:0] frame_q;
  logic                  ps2_clk_q, ps2_data_q, frame_done_q;

  logic       head_vld, pop, hp_done, gap_done, last_bit;
  logic [7:0] head_dat;

  assign hp_done  = (cnt_q == HP_LAST);
  assign gap_done = (cnt_q == GAP_LAST);
  assign last_bit = (bit_q == 4'(FRAME_BITS - 1));
  // The head is only released once the stop bit has fully gone out.
  assign pop      = (state_q == LOW) && hp_done && last_bit && !host_inhibit;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (in_valid),
    .push_dat_i (in_data),
    .push_rdy_o (in_ready),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .head_vld_o (head_vld),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      frame_q      <= '1;
      ps2_clk_q    <= 1'b1;
      ps2_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (head_vld && !host_inhibit) begin
          state_q                 <= SETUP;
          cnt_q                   <= '0;
          bit_q                   <= '0;
          ps2_clk_q               <= 1'b1;
          {frame_q, ps2_data_q}   <= build_frame(head_dat);
        end
        SETUP, LOW: begin
          if (host_inhibit) begin
            state_q    <= GAP;
            cnt_q      <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
          end else if (!hp_done) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (state_q == SETUP) begin
            state_q   <= LOW;
            cnt_q     <= '0;
            ps2_clk_q <= 1'b0;
          end else if (last_bit) begin
            state_q      <= GAP;
            cnt_q        <= '0;
            ps2_clk_q    <= 1'b1;
            ps2_data_q   <= 1'b1;
            frame_done_q <= 1'b1;
          end else begin
            // Data moves only together with the rising clock edge.
            state_q               <= SETUP;
            cnt_q                 <= '0;
            bit_q                 <= bit_q + 1'b1;
            ps2_clk_q             <= 1'b1;
            {frame_q, ps2_data_q} <= {1'b1, frame_q};
          end
        end
        GAP: begin
          if (gap_done) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with a line-level PS/2 receiver model.
module tb_ps2_kbd_tx;
  import ps2_kbd_tx_pkg::*;

  localparam int HP = 4;
  localparam int GP = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       host_inhibit = 1'b0;
  logic       in_ready, ps2_clk, ps2_data, busy, frame_done;
  logic [$clog2(DEPTH):0] fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_kbd_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .host_inhibit(host_inhibit), .ps2_clk(ps2_clk),
    .ps2_data(ps2_data), .busy(busy), .frame_done(frame_done),
    .fifo_count(fifo_count)
  );

  // Receiver model: samples the lines once per cycle, captures data on falling ps2_clk.
  int cyc = 0, nbits = 0, clk_hi_run = 0, both_hi_run = 0;
  int done_cnt = 0, frame_len = 0, setup_cyc = 0, gap_before = 0, viol = 0;
  logic prev_clk = 1'b1, prev_dat = 1'b1;
  logic [10:0] cur = '0;
  logic [10:0] rxq[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      nbits = 0; clk_hi_run = 0; both_hi_run = 0;
      prev_clk = 1'b1; prev_dat = 1'b1;
    end else begin
      if (ps2_data !== prev_dat && ps2_clk === 1'b0) viol++;
      if (prev_dat && !ps2_data && ps2_clk && nbits == 0) begin
        setup_cyc = cyc;
        gap_before = both_hi_run;
      end
      if (prev_clk && !ps2_clk && nbits < 11) begin
        cur[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          rxq.push_back(cur);
          nbits = 0;
        end
      end
      if (ps2_clk) clk_hi_run++; else clk_hi_run = 0;
      if (clk_hi_run >= 6) nbits = 0;
      if (ps2_clk && ps2_data) both_hi_run++; else both_hi_run = 0;
      if (frame_done) begin
        done_cnt++;
        frame_len = cyc - setup_cyc;
      end
      prev_clk = ps2_clk;
      prev_dat = ps2_data;
    end
  end

  function automatic logic [10:0] next_frame();
    if (rxq.size() > 0) return rxq.pop_front();
    return 11'h7FF;
  endfunction

  task automatic push(input logic [7:0] b);
    int t = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL push_accept: byte %h in_ready=%b after %0d cycles, required 1", b, in_ready, t);
    end
    @(posedge clk);
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int t = 0;
    while (busy && t < max_cyc) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, t);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL rst_clk: got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL rst_data: got %b want 1", ps2_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", frame_done); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_single;
    int d0 = done_cnt;
    logic [10:0] f;
    push(8'h1C);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    wait_idle(300);
    f = next_frame();
    checks++; if (f !== 11'b10000111000) begin errors++; $display("FAIL single_frame: got %b want 10000111000", f); end
    checks++; if (frame_len !== 88) begin errors++; $display("FAIL single_latency: got %0d want 88", frame_len); end
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL single_done_pulses: got %0d want %0d", done_cnt - d0, 1); end
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    int t = 0;
    logic [10:0] f;
    push(SC_BREAK);
    push(8'h1C);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count2: got %0d want 2", fifo_count); end
    while (done_cnt == d0 && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count1: got %0d want 1", fifo_count); end
    wait_idle(300);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_count0: got %0d want 0", fifo_count); end
    f = next_frame();
    checks++; if (f !== 11'b11111100000) begin errors++; $display("FAIL b2b_frame_f0: got %b want 11111100000", f); end
    checks++; if (f[9] !== 1'b1) begin errors++; $display("FAIL b2b_parity_f0: got %b want 1", f[9]); end
    f = next_frame();
    checks++; if (f !== 11'b10000111000) begin errors++; $display("FAIL b2b_frame_1c: got %b want 10000111000", f); end
    checks++; if (f[9] !== 1'b0) begin errors++; $display("FAIL b2b_parity_1c: got %b want 0", f[9]); end
    checks++; if (gap_before < 8) begin errors++; $display("FAIL b2b_gap: got %0d idle-high cycles want >=8", gap_before); end
  endtask

  task automatic test_full;
    logic [7:0] bytes [5];
    logic [10:0] f;
    bytes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    for (int i = 0; i < 4; i++) push(bytes[i]);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", in_ready); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
    push(bytes[4]);
    wait_idle(1500);
    checks++; if (rxq.size() !== 5) begin errors++; $display("FAIL full_nframes: got %0d want 5", rxq.size()); end
    for (int i = 0; i < 5; i++) begin
      f = next_frame();
      checks++;
      if (f[8:1] !== bytes[i]) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, f[8:1], bytes[i]); end
    end
  endtask

  task automatic test_inhibit;
    int d0 = done_cnt;
    int t = 0;
    logic [10:0] f;
    push(8'h00);
    while (nbits < 5 && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    host_inhibit = 1'b1;
    @(negedge clk); #1;
    checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL inh_clk_high: got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL inh_data_high: got %b want 1", ps2_data); end
    repeat (30) @(negedge clk);
    #1;
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL inh_no_done: got %0d pulses want 0", done_cnt - d0); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL inh_no_pop: got %0d want 1", fifo_count); end
    checks++; if (rxq.size() !== 0) begin errors++; $display("FAIL inh_no_frame: got %0d frames want 0", rxq.size()); end
    host_inhibit = 1'b0;
    wait_idle(400);
    f = next_frame();
    checks++; if (f !== 11'b11000000000) begin errors++; $display("FAIL inh_resend: got %b want 11000000000", f); end
    checks++; if (f[9] !== 1'b1) begin errors++; $display("FAIL inh_parity: got %b want 1", f[9]); end
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL inh_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe;
    int t = 0;
    int n0, d0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    while (nbits < 7 && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL mrst_clk: got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL mrst_data: got %b want 1", ps2_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mrst_count: got %0d want 0", fifo_count); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n0 = rxq.size();
    d0 = done_cnt;
    repeat (300) @(negedge clk);
    #1;
    checks++; if (rxq.size() !== n0) begin errors++; $display("FAIL mrst_no_frames: got %0d want %0d", rxq.size(), n0); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mrst_no_done: got %0d pulses want 0", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
    rxq.delete();
  endtask

  task automatic test_loop;
    logic [7:0] exp[$];
    logic [7:0] b;
    logic [10:0] f, want;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      exp.push_back(b);
      push(b);
    end
    wait_idle(2000);
    for (int i = 0; i < 256; i++) begin
      b = exp[i];
      want = {1'b1, ~^b, b, 1'b0};
      f = next_frame();
      checks++;
      if (f !== want) begin errors++; $display("FAIL loop[%0d]: got %b want %b", i, f, want); end
    end
  endtask

  task automatic test_protocol;
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL data_while_clk_low: got %0d changes want 0", viol); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_full;
    test_inhibit;
    test_reset_midframe;
    test_loop;
    test_protocol;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
